// File: rtl/handshake_arbiter_pkg.sv
// Shared FSM state encoding and default data width for the handshake arbiter.
package handshake_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREQ = 2'd1;
  localparam logic [1:0] ST_PREL = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/handshake_arbiter_sync_2ff.sv
// Two-flop synchronizer, W bits wide; 2 cycles of latency, no backpressure.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_d, s1_q;
  logic [W-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter bridging N 4-phase requesters onto one 4-phase pipeline.
// pipe_req_o rises 1 cycle after a synchronized request; waiting requesters simply hold req_i.
module handshake_arbiter
  import handshake_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*DATA_W-1:0]    data_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic                       pipe_req_o,
  output logic [DATA_W-1:0]          pipe_data_o,
  input  logic                       pipe_ack_i,
  output logic [$clog2(N_REQ)-1:0]   grant_o,
  output logic                       busy_o,
  output logic [7:0]                 xfer_cnt_o
);

  localparam int GW = $clog2(N_REQ);

  logic [N_REQ-1:0]  req_s;
  logic              pack_s;

  logic [1:0]        state_d, state_q;
  logic [GW-1:0]     grant_d, grant_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              preq_d, preq_q;
  logic [N_REQ-1:0]  ack_d, ack_q;
  logic [7:0]        cnt_d, cnt_q;

  logic              win_vld;
  logic [GW-1:0]     win_idx;
  int                rr_cand;

  sync_2ff #(.W(N_REQ)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d_i (req_i),
    .q_o (req_s)
  );

  sync_2ff #(.W(1)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d_i (pipe_ack_i),
    .q_o (pack_s)
  );

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = grant_q;
    rr_cand = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_cand = (int'(grant_q) + i) % N_REQ;
      if (!win_vld && req_s[rr_cand]) begin
        win_vld = 1'b1;
        win_idx = GW'(rr_cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    preq_d  = preq_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld && !pack_s) begin
          state_d = ST_PREQ;
          grant_d = win_idx;
          data_d  = data_i[int'(win_idx)*DATA_W +: DATA_W];
          preq_d  = 1'b1;
        end
      end
      ST_PREQ: begin
        if (pack_s) begin
          state_d = ST_PREL;
          preq_d  = 1'b0;
        end
      end
      ST_PREL: begin
        if (!pack_s) begin
          state_d        = ST_DONE;
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          cnt_d          = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        if (!req_s[grant_q]) begin
          state_d = ST_IDLE;
          ack_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= GW'(N_REQ - 1);
      data_q  <= '0;
      preq_q  <= 1'b0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      preq_q  <= preq_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack_o       = ack_q;
  assign pipe_req_o  = preq_q;
  assign pipe_data_o = data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign xfer_cnt_o  = cnt_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboarded bench: requester and pipeline 4-phase models, grants checked against a queue.
module tb_handshake_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ack_o;
  logic           pipe_req_o;
  logic [W-1:0]   pipe_data_o;
  logic           pipe_ack_i;
  logic [1:0]     grant_o;
  logic           busy_o;
  logic [7:0]     xfer_cnt_o;

  handshake_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .pipe_req_o  (pipe_req_o),
    .pipe_data_o (pipe_data_o),
    .pipe_ack_i  (pipe_ack_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .xfer_cnt_o  (xfer_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   g;
    logic [W-1:0] d;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           rem[N];
  logic [W-1:0] dval[N];
  bit           pipe_force = 1'b0;
  int           pcnt = 0;
  int           req_cyc = 0;
  int           rise_cyc = 0;
  logic [N-1:0] last_ack = '0;
  logic         prev_preq = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor, requester model and pipeline model share one process for a fixed order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pipe_req_o && !prev_preq) begin
          rise_cyc = cyc;
          check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("grant", 32'(grant_o), 32'(e.g));
            check("pipe_data", 32'(pipe_data_o), 32'(e.d));
          end
        end else begin
          check("data_stable", 32'(pipe_data_o), 32'(prev_data));
        end
        if (ack_o != '0) begin
          last_ack = ack_o;
          check("ack_onehot", 32'(ack_o), 32'(4'b0001 << grant_o));
          check("ack_busy", 32'(busy_o), 32'd1);
        end
        for (int k = 0; k < N; k++) begin
          if (ack_o[k] && req_i[k]) begin
            req_i[k] = 1'b0;
          end else if (!ack_o[k] && !req_i[k] && rem[k] > 0) begin
            data_i[k*W +: W] = dval[k];
            req_i[k] = 1'b1;
            rem[k]--;
            req_cyc = cyc;
          end
        end
        if (pipe_force) begin
          pipe_ack_i = 1'b1;
        end else if (pipe_req_o != pipe_ack_i) begin
          pcnt++;
          if (pcnt >= 2) begin
            pipe_ack_i = pipe_req_o;
            pcnt = 0;
          end
        end else begin
          pcnt = 0;
        end
      end
      prev_preq = pipe_req_o;
      prev_data = pipe_data_o;
    end
  end

  task automatic clear_models();
    req_i = '0;
    pipe_ack_i = pipe_force;
    pcnt = 0;
    for (int k = 0; k < N; k++) rem[k] = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_models();
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_preq", 32'(pipe_req_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_data", 32'(pipe_data_o), 32'd0);
    check("rst_cnt", 32'(xfer_cnt_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd3);
    rst = 1'b0;
    last_ack = '0;
  endtask

  task automatic wait_done(input int budget);
    int  t;
    bit  idle;
    t = 0;
    idle = 1'b0;
    while (!idle && t < budget) begin
      @(negedge clk);
      #2;
      t++;
      idle = (req_i == '0) && !busy_o && (sb.size() == 0);
      for (int k = 0; k < N; k++) if (rem[k] != 0) idle = 1'b0;
    end
    check("done_in_budget", 32'(idle), 32'd1);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    req_i = '0;
    data_i = '0;
    pipe_ack_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      rem[k] = 0;
      dval[k] = '0;
    end

    // Single requester, latency and first transfer
    do_reset();
    dval[0] = 16'hA1A1;
    sb.push_back('{2'd0, 16'hA1A1});
    rem[0] = 1;
    wait_done(2000);
    check("req_to_preq_latency", 32'(rise_cyc - req_cyc), 32'd3);
    check("single_ack", 32'(last_ack), 32'b0001);
    check("single_cnt", 32'(xfer_cnt_o), 32'd1);
    check("single_data_hold", 32'(pipe_data_o), 32'hA1A1);

    // All four requesting: round-robin from requester 0
    do_reset();
    for (int k = 0; k < N; k++) begin
      dval[k] = 16'hB0B0 + 16'(k);
      sb.push_back('{2'(k), 16'hB0B0 + 16'(k)});
      rem[k] = 1;
    end
    wait_done(4000);
    check("all4_cnt", 32'(xfer_cnt_o), 32'd4);
    check("all4_last_grant", 32'(grant_o), 32'd3);

    // Requesters 0 and 2 alternating
    do_reset();
    dval[0] = 16'h5A00;
    dval[2] = 16'h5A02;
    sb.push_back('{2'd0, 16'h5A00});
    sb.push_back('{2'd2, 16'h5A02});
    sb.push_back('{2'd0, 16'h5A00});
    sb.push_back('{2'd2, 16'h5A02});
    rem[0] = 2;
    rem[2] = 2;
    wait_done(4000);
    check("alt_cnt", 32'(xfer_cnt_o), 32'd4);

    // Reset in the middle of a pipeline request
    do_reset();
    dval[0] = 16'hC3C3;
    sb.push_back('{2'd0, 16'hC3C3});
    rem[0] = 1;
    t = 0;
    while (!pipe_req_o && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    check("reach_preq", 32'(pipe_req_o), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_preq", 32'(pipe_req_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_data", 32'(pipe_data_o), 32'd0);
    check("midrst_cnt", 32'(xfer_cnt_o), 32'd0);
    check("midrst_grant", 32'(grant_o), 32'd3);
    check("midrst_ack", 32'(ack_o), 32'd0);
    clear_models();
    repeat (3) @(negedge clk);
    #2;
    check("midrst_no_ack", 32'(last_ack), 32'd0);
    rst = 1'b0;
    dval[0] = 16'h1234;
    sb.push_back('{2'd0, 16'h1234});
    rem[0] = 1;
    wait_done(2000);
    check("post_rst_cnt", 32'(xfer_cnt_o), 32'd1);
    check("post_rst_data", 32'(pipe_data_o), 32'h1234);

    // pipe_ack stuck high blocks grants
    pipe_force = 1'b1;
    do_reset();
    dval[1] = 16'hD1D1;
    sb.push_back('{2'd1, 16'hD1D1});
    rem[1] = 1;
    repeat (20) @(negedge clk);
    #2;
    check("blocked_preq", 32'(pipe_req_o), 32'd0);
    check("blocked_busy", 32'(busy_o), 32'd0);
    pipe_force = 1'b0;
    wait_done(2000);
    check("unblock_grant", 32'(grant_o), 32'd1);
    check("unblock_cnt", 32'(xfer_cnt_o), 32'd1);

    // 256 transfers wrap the counter
    do_reset();
    dval[0] = 16'hE0E0;
    for (int i = 0; i < 256; i++) sb.push_back('{2'd0, 16'hE0E0});
    rem[0] = 256;
    wait_done(20000);
    check("wrap_cnt", 32'(xfer_cnt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
